// File: rtl/entrada_condicionador.sv
// Input conditioning for the lighting controller: synchronises and debounces the
// button and IR pins, and turns button presses into short/long single-cycle pulses.
module entrada_condicionador #(
    parameter int unsigned DEBOUNCE_P        = 300,
    parameter int unsigned SWITCH_MODE_MIN_T = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic push_button,
    input  logic infravermelho,
    output logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic ir_presence,
    output logic ir_rise
);

    localparam int unsigned DW = $clog2(DEBOUNCE_P + 1);
    localparam int unsigned HW = $clog2(SWITCH_MODE_MIN_T + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    logic          b_ff1, b_ff2, i_ff1, i_ff2;
    logic [DW-1:0] b_cnt, b_cnt_d, i_cnt, i_cnt_d;
    logic          b_stable_d, i_stable_d;

    state_t        state, state_d;
    logic [HW-1:0] hold_cnt, hold_d;
    logic          short_d, long_d;

    // Two-flop synchronisers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_ff1 <= 1'b0;
            b_ff2 <= 1'b0;
            i_ff1 <= 1'b0;
            i_ff2 <= 1'b0;
        end else begin
            b_ff1 <= push_button;
            b_ff2 <= b_ff1;
            i_ff1 <= infravermelho;
            i_ff2 <= i_ff1;
        end
    end

    // Debounce: stable follows sync after DEBOUNCE_P consecutive mismatching cycles
    always_comb begin
        b_stable_d = btn_level;
        b_cnt_d    = '0;
        if (b_ff2 != btn_level) begin
            if (b_cnt == DW'(DEBOUNCE_P - 1)) b_stable_d = b_ff2;
            else                              b_cnt_d    = b_cnt + DW'(1);
        end
        i_stable_d = ir_presence;
        i_cnt_d    = '0;
        if (i_ff2 != ir_presence) begin
            if (i_cnt == DW'(DEBOUNCE_P - 1)) i_stable_d = i_ff2;
            else                              i_cnt_d    = i_cnt + DW'(1);
        end
    end

    // Press classifier runs on the next stable level so pulses align with btn_level
    always_comb begin
        state_d = state;
        hold_d  = hold_cnt;
        short_d = 1'b0;
        long_d  = 1'b0;
        case (state)
            IDLE: begin
                if (b_stable_d) begin
                    state_d = PRESSED;
                    hold_d  = HW'(1);
                end
            end
            PRESSED: begin
                if (b_stable_d) begin
                    hold_d = hold_cnt + HW'(1);
                    if (hold_cnt + HW'(1) == HW'(SWITCH_MODE_MIN_T)) begin
                        long_d  = 1'b1;
                        state_d = HELD;
                    end
                end else begin
                    short_d = 1'b1;
                    hold_d  = '0;
                    state_d = IDLE;
                end
            end
            HELD: begin
                if (!b_stable_d) begin
                    hold_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                hold_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_cnt       <= '0;
            i_cnt       <= '0;
            btn_level   <= 1'b0;
            ir_presence <= 1'b0;
            ir_rise     <= 1'b0;
            state       <= IDLE;
            hold_cnt    <= '0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            b_cnt       <= b_cnt_d;
            i_cnt       <= i_cnt_d;
            btn_level   <= b_stable_d;
            ir_presence <= i_stable_d;
            ir_rise     <= i_stable_d & ~ir_presence;
            state       <= state_d;
            hold_cnt    <= hold_d;
            short_press <= short_d;
            long_press  <= long_d;
        end
    end

endmodule
